// File: rtl/if_stage_if.sv
// if_stage_if: pre-IF, ICache-response and ID-side signals of the fetch stage.
// master = environment driving the stage, slave = the fetch stage itself.
interface if_stage_if;
   localparam int unsigned PS_TO_FS_BUS_WD = 39;
   localparam int unsigned FS_TO_DS_BUS_WD = 70;

   logic                       ps_to_fs_valid;
   logic [PS_TO_FS_BUS_WD-1:0] ps_to_fs_bus;
   logic                       fs_allowin;
   logic                       inst_rdata_valid;
   logic [31:0]                inst_rdata;
   logic                       flush;
   logic                       ds_allowin;
   logic                       fs_to_ds_valid;
   logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;

   modport master (
      output ps_to_fs_valid, ps_to_fs_bus, inst_rdata_valid, inst_rdata, flush, ds_allowin,
      input  fs_allowin, fs_to_ds_valid, fs_to_ds_bus
   );

   modport slave (
      input  ps_to_fs_valid, ps_to_fs_bus, inst_rdata_valid, inst_rdata, flush, ds_allowin,
      output fs_allowin, fs_to_ds_valid, fs_to_ds_bus
   );
endinterface

// File: rtl/if_stage.sv
// if_stage: fetch stage. Takes one pre-IF entry, waits for its ICache word (bypassed to ID
// in the arrival cycle, or held in a one-entry buffer while ID stalls), and drops responses
// that belong to fetches squashed by flush.
// Optional macro FS_STALL_CNT_EN: enables the fs_stall_cnt cycle counter (tied to 0 otherwise).
module if_stage (
   input  logic        clk,
   input  logic        reset,
   if_stage_if.slave   fs_if,
   output logic [31:0] fs_stall_cnt
);

   // Pre-IF bus fields: {req, pc, ex, exctype}
   logic        w_ps_req;
   logic [31:0] w_ps_pc;
   logic        w_ps_ex;
   logic [4:0]  w_ps_exctype;
   assign {w_ps_req, w_ps_pc, w_ps_ex, w_ps_exctype} = fs_if.ps_to_fs_bus;

   // Current entry
   logic        r_fs_valid;
   logic [31:0] r_fs_pc;
   logic        r_fs_req;
   logic        r_fs_ex;
   logic [4:0]  r_fs_exctype;

   // One-entry instruction buffer and count of responses owed to squashed fetches
   logic        r_buf_valid;
   logic [31:0] r_buf_inst;
   logic [1:0]  r_drop_cnt;
   logic [1:0]  w_drop_cnt_nxt;

   logic        w_drop_pending;
   logic        w_word_drop;
   logic        w_waiting;
   logic        w_word_mine;
   logic        w_data_ok;
   logic        w_ready_go;
   logic [31:0] w_inst;
   logic        w_to_ds_valid;
   logic        w_allowin;
   logic        w_accept;
   logic        w_handoff;
   logic        w_drop_inc;

   assign w_drop_pending = (r_drop_cnt != 2'd0);
   assign w_word_drop    = fs_if.inst_rdata_valid & w_drop_pending;
   assign w_waiting      = r_fs_valid & r_fs_req & ~r_buf_valid;
   assign w_word_mine    = fs_if.inst_rdata_valid & ~w_drop_pending & w_waiting;
   assign w_data_ok      = r_buf_valid | (fs_if.inst_rdata_valid & ~w_drop_pending);
   assign w_ready_go     = ~r_fs_valid | r_fs_ex | ~r_fs_req | w_data_ok;
   assign w_inst         = r_fs_ex     ? 32'h0      :
                           r_buf_valid ? r_buf_inst : fs_if.inst_rdata;
   assign w_to_ds_valid  = r_fs_valid & w_ready_go & ~fs_if.flush;
   assign w_allowin      = ~r_fs_valid | (w_ready_go & fs_if.ds_allowin);
   assign w_accept       = fs_if.ps_to_fs_valid & w_allowin & ~fs_if.flush;
   assign w_handoff      = w_to_ds_valid & fs_if.ds_allowin;
   // A squashed entry whose word has not arrived leaves one response to discard later
   assign w_drop_inc     = fs_if.flush & w_waiting & ~w_word_mine;

   assign fs_if.fs_allowin     = w_allowin;
   assign fs_if.fs_to_ds_valid = w_to_ds_valid;
   // Bus reads as zero when no entry is held, so idle ICache noise never leaks out
   assign fs_if.fs_to_ds_bus   = r_fs_valid ? {r_fs_pc, w_inst, r_fs_ex, r_fs_exctype} : 70'd0;

   // Next drop count: +1 per squashed waiting fetch (saturating), -1 per discarded word
   always_comb begin
      w_drop_cnt_nxt = r_drop_cnt;
      if (w_drop_inc && !w_word_drop) begin
         if (r_drop_cnt != 2'd3) begin
            w_drop_cnt_nxt = r_drop_cnt + 2'd1;
         end
      end else if (w_word_drop && !w_drop_inc) begin
         w_drop_cnt_nxt = r_drop_cnt - 2'd1;
      end
   end

   // Drop counter register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_drop_cnt <= 2'd0;
      end else begin
         r_drop_cnt <= w_drop_cnt_nxt;
      end
   end

   // Entry register: load on accept, clear on handoff or flush
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fs_valid   <= 1'b0;
         r_fs_pc      <= 32'd0;
         r_fs_req     <= 1'b0;
         r_fs_ex      <= 1'b0;
         r_fs_exctype <= 5'd0;
      end else if (fs_if.flush) begin
         r_fs_valid <= 1'b0;
      end else if (w_accept) begin
         // req=0/ex=0 is a cancelled slot and leaves the stage empty
         r_fs_valid   <= w_ps_req | w_ps_ex;
         r_fs_pc      <= w_ps_pc;
         r_fs_req     <= w_ps_req;
         r_fs_ex      <= w_ps_ex;
         r_fs_exctype <= w_ps_exctype;
      end else if (w_handoff) begin
         r_fs_valid <= 1'b0;
      end
   end

   // Instruction buffer: capture the entry's word when ID cannot take it this cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         r_buf_valid <= 1'b0;
         r_buf_inst  <= 32'd0;
      end else if (fs_if.flush || w_handoff) begin
         r_buf_valid <= 1'b0;
      end else if (w_word_mine) begin
         r_buf_valid <= 1'b1;
         r_buf_inst  <= fs_if.inst_rdata;
      end
   end

`ifdef FS_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   // Count cycles an entry sits waiting on ICache data (not on ID, not while flushing)
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= 32'd0;
      end else if (r_fs_valid && !w_ready_go && !fs_if.flush) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign fs_stall_cnt = r_stall_cnt;
`else
   assign fs_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench for if_stage. Accepted entries push their expected ID bus
// into a queue; a separate monitor pops and compares on every ID handoff.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] fs_stall_cnt;

   if_stage_if bus_if ();

   if_stage dut (
      .clk          (clk),
      .reset        (reset),
      .fs_if        (bus_if),
      .fs_stall_cnt (fs_stall_cnt)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;

   // ICache model: words[i] answers the i-th accepted request, in order
   logic [31:0] words[$];
   int          req_idx  = 0;
   int          resp_idx = 0;
   logic [69:0] exp_q[$];
   logic [31:0] c0;

   function automatic void check1(string name, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endfunction

   function automatic void check32(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic void check70(string name, logic [69:0] act, logic [69:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Drive one cycle of inputs; rv returns the next owed ICache word if any
   task automatic apply(input bit pv, input bit rq, input logic [31:0] pc, input bit ex,
                        input logic [4:0] et, input bit rv, input bit fl, input bit dsa);
      bus_if.ps_to_fs_valid = pv;
      bus_if.ps_to_fs_bus   = {rq, pc, ex, et};
      bus_if.flush          = fl;
      bus_if.ds_allowin     = dsa;
      if (rv && resp_idx < words.size()) begin
         bus_if.inst_rdata_valid = 1'b1;
         bus_if.inst_rdata       = words[resp_idx];
         resp_idx++;
      end else begin
         bus_if.inst_rdata_valid = 1'b0;
         bus_if.inst_rdata       = $urandom;
      end
   endtask

   task automatic drv(input bit pv, input bit rq, input logic [31:0] pc, input bit ex,
                      input logic [4:0] et, input bit rv, input bit fl, input bit dsa);
      @(negedge clk);
      apply(pv, rq, pc, ex, et, rv, fl, dsa);
   endtask

   task automatic idle();
      drv(1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      apply(1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      #1;
      check1("rst_valid", bus_if.fs_to_ds_valid, 1'b0);
      check70("rst_bus", bus_if.fs_to_ds_bus, 70'd0);
      check1("rst_allowin", bus_if.fs_allowin, 1'b1);
      check32("rst_stall_cnt", fs_stall_cnt, 32'd0);
      words.delete();
      exp_q.delete();
      req_idx  = 0;
      resp_idx = 0;
      reset    = 1'b0;
   endtask

   // Reference model: every accepted non-cancelled entry is owed one ID handoff carrying
   // its own ICache word (or zero for an exception entry) unless a flush squashes it first.
   initial begin : model
      logic        m_req;
      logic [31:0] m_pc;
      logic        m_ex;
      logic [4:0]  m_et;
      forever begin
         @(negedge clk);
         #4;
         if (reset || bus_if.flush) begin
            exp_q.delete();
         end else if (bus_if.ps_to_fs_valid && bus_if.fs_allowin) begin
            {m_req, m_pc, m_ex, m_et} = bus_if.ps_to_fs_bus;
            if (m_req) begin
               if (req_idx >= words.size()) words.push_back($urandom);
               exp_q.push_back({m_pc, words[req_idx], m_ex, m_et});
               req_idx++;
            end else if (m_ex) begin
               exp_q.push_back({m_pc, 32'h0, 1'b1, m_et});
            end
         end
      end
   end

   // Monitor: compare every handoff against the scoreboard head
   initial begin : monitor
      logic [69:0] e;
      forever begin
         @(negedge clk);
         #3;
         if (!reset) begin
            if (bus_if.flush) begin
               check1("no_valid_in_flush", bus_if.fs_to_ds_valid, 1'b0);
            end else if (bus_if.fs_to_ds_valid && bus_if.ds_allowin) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL handoff_unexpected: got bus %h expected no handoff",
                           bus_if.fs_to_ds_bus);
               end else begin
                  e = exp_q.pop_front();
                  check70("handoff_bus", bus_if.fs_to_ds_bus, e);
               end
            end
         end
      end
   end

   initial begin : main
      reset = 1'b1;
      apply(1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      do_reset();

      // Basic fetch with zero-cycle bypass
      words = '{32'h24010001};
      drv(1, 1, 32'hBFC00000, 0, 5'd0, 0, 0, 1);
      #1 check1("t1_allowin_idle", bus_if.fs_allowin, 1'b1);
      drv(0, 0, 32'd0, 0, 5'd0, 1, 0, 1);
      #1 check1("t1_valid", bus_if.fs_to_ds_valid, 1'b1);
      check70("t1_bus", bus_if.fs_to_ds_bus, {32'hBFC00000, 32'h24010001, 1'b0, 5'd0});
      idle();
      #1 check1("t1_one_cycle", bus_if.fs_to_ds_valid, 1'b0);

      // ID stall: word buffered for three cycles
      do_reset();
      words = '{32'h3C1D8000};
      c0 = fs_stall_cnt;
      drv(1, 1, 32'hBFC00004, 0, 5'd0, 0, 0, 1);
      drv(0, 0, 32'd0, 0, 5'd0, 1, 0, 0);
      #1 check1("t2_valid_arrival", bus_if.fs_to_ds_valid, 1'b1);
      check1("t2_allowin_0", bus_if.fs_allowin, 1'b0);
      for (int i = 0; i < 2; i++) begin
         drv(0, 0, 32'd0, 0, 5'd0, 0, 0, 0);
         #1 check1("t2_allowin_hold", bus_if.fs_allowin, 1'b0);
         check70("t2_buf_bus", bus_if.fs_to_ds_bus, {32'hBFC00004, 32'h3C1D8000, 1'b0, 5'd0});
      end
      idle();
      #1 check1("t2_valid_release", bus_if.fs_to_ds_valid, 1'b1);
      check32("t2_stall_delta", fs_stall_cnt - c0, 32'd0);
      idle();
      #1 check1("t2_drained", bus_if.fs_to_ds_valid, 1'b0);

      // Address error entry: handoff next cycle with inst = 0
      do_reset();
      drv(1, 0, 32'hBFC00002, 1, 5'h04, 0, 0, 1);
      idle();
      #1 check1("t3_valid", bus_if.fs_to_ds_valid, 1'b1);
      check70("t3_bus", bus_if.fs_to_ds_bus, {32'hBFC00002, 32'h0, 1'b1, 5'h04});
      idle();
      #1 check1("t3_gone", bus_if.fs_to_ds_valid, 1'b0);
      check1("t3_allowin", bus_if.fs_allowin, 1'b1);

      // Flush while waiting: stale word dropped, next entry gets the following word
      do_reset();
      words = '{32'hDEADBEEF, 32'h00000000};
      c0 = fs_stall_cnt;
      drv(1, 1, 32'hBFC00010, 0, 5'd0, 0, 0, 1);
      idle();
      #1 check1("t4_wait_valid", bus_if.fs_to_ds_valid, 1'b0);
      check1("t4_wait_allowin", bus_if.fs_allowin, 1'b0);
      drv(0, 0, 32'd0, 0, 5'd0, 0, 1, 1);
      #1 check1("t4_flush_valid", bus_if.fs_to_ds_valid, 1'b0);
      drv(1, 1, 32'hBFC00380, 0, 5'd0, 1, 0, 1);
      #1 check1("t4_drop_valid", bus_if.fs_to_ds_valid, 1'b0);
      check1("t4_drop_allowin", bus_if.fs_allowin, 1'b1);
      drv(0, 0, 32'd0, 0, 5'd0, 1, 0, 1);
      #1 check1("t4_valid", bus_if.fs_to_ds_valid, 1'b1);
      check70("t4_bus", bus_if.fs_to_ds_bus, {32'hBFC00380, 32'h00000000, 1'b0, 5'd0});
      idle();
`ifdef FS_STALL_CNT_EN
      check32("t4_stall_delta", fs_stall_cnt - c0, 32'd1);
`else
      check32("t4_stall_tied", fs_stall_cnt, 32'd0);
`endif

      // Double flush: two responses dropped, third delivered
      do_reset();
      words = '{32'h11111111, 32'h22222222, 32'h33333333};
      drv(1, 1, 32'hBFC00100, 0, 5'd0, 0, 0, 1);
      drv(0, 0, 32'd0, 0, 5'd0, 0, 1, 1);
      drv(1, 1, 32'hBFC00104, 0, 5'd0, 0, 0, 1);
      drv(0, 0, 32'd0, 0, 5'd0, 0, 1, 1);
      drv(1, 1, 32'hBFC00108, 0, 5'd0, 0, 0, 1);
      for (int i = 0; i < 2; i++) begin
         drv(0, 0, 32'd0, 0, 5'd0, 1, 0, 1);
         #1 check1("t5_dropped", bus_if.fs_to_ds_valid, 1'b0);
      end
      drv(0, 0, 32'd0, 0, 5'd0, 1, 0, 1);
      #1 check1("t5_valid", bus_if.fs_to_ds_valid, 1'b1);
      check70("t5_bus", bus_if.fs_to_ds_bus, {32'hBFC00108, 32'h33333333, 1'b0, 5'd0});

      // Cancelled slot
      do_reset();
      drv(1, 0, 32'hBFC00200, 0, 5'd0, 0, 0, 1);
      idle();
      #1 check1("t6_valid", bus_if.fs_to_ds_valid, 1'b0);
      check1("t6_allowin", bus_if.fs_allowin, 1'b1);

      // Back-to-back: one instruction per cycle with simultaneous handoff and accept
      do_reset();
      words = '{32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hA0000003};
      drv(1, 1, 32'hBFC00300, 0, 5'd0, 0, 0, 1);
      for (int i = 1; i < 4; i++) begin
         drv(1, 1, 32'hBFC00300 + 32'(4 * i), 0, 5'd0, 1, 0, 1);
         #1 check1("t7_valid", bus_if.fs_to_ds_valid, 1'b1);
         check1("t7_allowin", bus_if.fs_allowin, 1'b1);
      end
      drv(0, 0, 32'd0, 0, 5'd0, 1, 0, 1);
      #1 check1("t7_last", bus_if.fs_to_ds_valid, 1'b1);
      idle();

      // Reset clears a pending drop count
      do_reset();
      words = '{32'hAAAA0001};
      drv(1, 1, 32'hBFC00400, 0, 5'd0, 0, 0, 1);
      drv(0, 0, 32'd0, 0, 5'd0, 0, 1, 1);
      do_reset();
      words = '{32'hC0DE0003};
      drv(1, 1, 32'hBFC00404, 0, 5'd0, 0, 0, 1);
      drv(0, 0, 32'd0, 0, 5'd0, 1, 0, 1);
      #1 check1("t8_valid", bus_if.fs_to_ds_valid, 1'b1);
      check70("t8_bus", bus_if.fs_to_ds_bus, {32'hBFC00404, 32'hC0DE0003, 1'b0, 5'd0});
      idle();

      // Randomized traffic; at most three ICache requests outstanding
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         bit rv;
         bit pv;
         bit rq;
         bit ex;
         bit fl;
         bit dsa;
         int k;
         int outs;
         @(negedge clk);
         rv   = (req_idx > resp_idx) && ($urandom_range(0, 1) == 1);
         pv   = ($urandom_range(0, 9) < 7);
         k    = $urandom_range(0, 9);
         outs = req_idx - resp_idx - (rv ? 1 : 0);
         rq   = 1'b0;
         ex   = 1'b0;
         if (k >= 2 && outs < 3) rq = 1'b1;
         else if (k != 0) ex = 1'b1;
         fl   = ($urandom_range(0, 19) == 0);
         dsa  = ($urandom_range(0, 3) != 0);
         apply(pv, rq, $urandom, ex, 5'($urandom_range(0, 31)), rv, fl, dsa);
      end
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         apply(0, 0, 32'd0, 0, 5'd0, req_idx > resp_idx, 0, 1);
      end
      @(negedge clk);
      #5 check32("drain_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_stage.md
# if_stage

Fetch (IF) stage of the AXI pipeline, directly downstream of the pre-IF stage. Accepts the pre-IF bus (PC, ICache-request flag, fetch exception), waits for the matching ICache read data, and holds it in a one-entry buffer while ID stalls. Presents {PC, instruction, exception} to ID. On flush it discards the in-flight ICache responses that belong to squashed fetches.

## Interface
Parameters:
- none; bus widths come from `global_defines.vh`: `PS_TO_FS_BUS_WD` = 39, `FS_TO_DS_BUS_WD` = 70.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- ps_to_fs_valid  in  1  pre-IF entry available
- ps_to_fs_bus  in  39  {req[38], pc[37:6], ex[5], exctype[4:0]}
- fs_allowin  out  1  IF can take a new entry this cycle
- inst_rdata_valid  in  1  ICache returns one word; responses arrive in request order
- inst_rdata  in  32  returned instruction word
- flush  in  1  exception/eret squash from M1
- ds_allowin  in  1  ID can accept
- fs_to_ds_valid  out  1  entry handed to ID this cycle
- fs_to_ds_bus  out  70  {pc[69:38], inst[37:6], ex[5], exctype[4:0]}
- fs_stall_cnt  out  32  stall counter, see Configuration

## Operation
- State: fs_valid, fs_pc, fs_req, fs_ex, fs_exctype, buf_valid, buf_inst, drop_cnt[1:0].
- Accept when ps_to_fs_valid & fs_allowin & ~flush.
  - Entry with req=0 and ex=0 is a cancelled slot: fs_valid is not set.
  - Any other entry sets fs_valid and loads fs_* from the bus.
- Response routing when inst_rdata_valid:
  - drop_cnt != 0: discard the word, drop_cnt−1.
  - Else, fs_valid & fs_req & ~buf_valid: the word belongs to the current entry.
  - Else: protocol error; the word is ignored.
- data_ok = buf_valid | (inst_rdata_valid & drop_cnt==0).
- fs_ready_go = ~fs_valid | fs_ex | ~fs_req | data_ok.
- inst = fs_ex ? 32'h0 : buf_valid ? buf_inst : inst_rdata.
- fs_to_ds_valid = fs_valid & fs_ready_go & ~flush.
- fs_allowin = ~fs_valid | (fs_ready_go & ds_allowin).
- Buffer:
  - Loads buf_inst/buf_valid when the word for the current entry arrives and ~(fs_to_ds_valid & ds_allowin).
  - Clears on handoff.
- Handoff (fs_to_ds_valid & ds_allowin) without a new accept clears fs_valid.
- Flush:
  - Clears fs_valid and buf_valid; the input entry is not accepted that cycle.
  - If fs_valid & fs_req & ~buf_valid and no word for the entry arrives this cycle, drop_cnt+1 (saturating at 3).
  - A word arriving in the flush cycle is consumed by the routing rules above and never reaches ID.

## Timing
- Reset: fs_valid=0, buf_valid=0, drop_cnt=0, fs_to_ds_valid=0, fs_to_ds_bus=0, fs_allowin=1, fs_stall_cnt=0.
- Accept at edge N → earliest fs_to_ds_valid in cycle N+1, combinationally from inst_rdata_valid (zero-cycle data bypass).
- Exception entries hand off the cycle after accept with inst = 0.
- Back-to-back throughput: one instruction per cycle when the ICache returns in the cycle after the request and ID does not stall.
- Simultaneous handoff and accept: fs_* reload; fs_valid stays 1.
- Reset mid-operation clears drop_cnt: responses outstanding at reset are the ICache's responsibility.

## Configuration
- Macro `FS_STALL_CNT_EN`.
- Defined: fs_stall_cnt counts cycles with fs_valid & ~fs_ready_go & ~flush. The counter wraps modulo 2^32 and clears on reset.
- Undefined: fs_stall_cnt tied to 0 and no counter logic is generated.

## Test plan
- Basic fetch: accept pc=0xBFC00000, req=1. Rdata 0x24010001 in the next cycle with ds_allowin=1 → fs_to_ds_bus {0xBFC00000, 0x24010001, 0, 0}, fs_to_ds_valid for exactly 1 cycle.
- ID stall: rdata 0x3C1D8000 arrives while ds_allowin=0 for 3 cycles → buffered, fs_allowin=0 throughout, same word handed off when ds_allowin=1. With `FS_STALL_CNT_EN` the counter does not increment while waiting on ID.
- Address error: accept pc=0xBFC00002, req=0, ex=1, exctype=AdEL → handoff next cycle with inst=0, ex=1, no ICache data consumed.
- Flush while waiting: req=1 entry with no data, then flush → drop_cnt=1. Next rdata 0xDEADBEEF is discarded. The following entry pc=0xBFC00380 receives the next word 0x00000000 correctly.
- Double flush: two flushes, each while waiting on outstanding data → drop_cnt reaches 2. The next two responses are dropped, the third is delivered.
- Cancelled slot: accept req=0, ex=0 → fs_valid stays 0 and no fs_to_ds_valid.
